float_alu_issue: RTL and testbench
==================================

// Module: float_alu_issue
// PURPOSE
//  Upstream issue stage for float_alu. Buffers ALU commands (op_code, round_mode, mode_fp, op_a, op_b) in a FIFO.
//  Issues one command at a time with a one-cycle start pulse when the ALU reports ready.
//  Holds the operands stable while the ALU works, then captures result and flags on valid_out.
//  Presents each captured result with a sequence tag for the downstream writeback.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of 2, >=2
//  TAG_W  4  width of result sequence tag
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      synchronous, active-high reset
//  cmd_valid       in   1      command offered
//  cmd_ready       out  1      FIFO can accept (=!full)
//  cmd_op_code     in   3      ALU operation
//  cmd_round_mode  in   1      rounding mode
//  cmd_mode_fp     in   1      fp/int mode select
//  cmd_op_a        in   32     operand A
//  cmd_op_b        in   32     operand B
//  level           out  clog2(DEPTH)+1  FIFO occupancy
//  alu_start       out  1      one-cycle start pulse to float_alu
//  alu_op_code/alu_round_mode/alu_mode_fp/alu_op_a/alu_op_b  out  3/1/1/32/32  held operands
//  alu_ready       in   1      float_alu ready_out
//  alu_valid       in   1      float_alu valid_out
//  alu_result      in   32     float_alu result
//  alu_flags       in   5      float_alu flags
//  res_valid       out  1      one-cycle result strobe
//  res_result      out  32     captured result
//  res_flags       out  5      captured flags
//  res_tag         out  TAG_W  sequence number of this result (0,1,2..., wraps mod 2^TAG_W)
// BEHAVIOUR
//  Reset: FIFO empty, level=0, cmd_ready=1, state IDLE, alu_start=0, all alu_* operands 0,
//   res_valid=0, res_result=0, res_flags=0, res_tag=0, issue counter=0.
//  Push on cmd_valid&&cmd_ready. Full => cmd_ready=0; there is no bypass when full.
//  Pointers wrap mod DEPTH. Simultaneous push+pop keeps level unchanged.
//  FSM IDLE: if !empty && alu_ready, then pop the head into the alu_* registers and go to ISSUE.
//  FSM ISSUE: alu_start=1 for this cycle only; go to WAIT. alu_valid is ignored here.
//  FSM WAIT: alu_* outputs stay constant. On alu_valid, register alu_result/alu_flags into res_*.
//   res_tag=issue counter; counter+1; res_valid=1 next cycle only; go to IDLE.
//  alu_valid seen in IDLE or ISSUE is ignored.
//  Latency: command accepted at edge E0 into an empty FIFO with alu_ready=1:
//   alu_start is high during the cycle after E1.
//   res_valid is high during the cycle after the edge that samples alu_valid.
//   At least one IDLE cycle separates consecutive issues.
//  Only one command is outstanding at a time; level excludes the in-flight command.
//  Reset mid-operation: the in-flight command and the queued commands are discarded.
//   A later alu_valid is ignored. The tag restarts at 0.
// CONFIGURATION
//  FALU_STICKY_FLAGS_EN defined: adds port flags_clr (in,1) and port flags_sticky (out,5).
//   flags_sticky |= alu_flags on each captured result.
//   flags_clr zeroes flags_sticky; if a capture lands in the same cycle, that capture's flags are retained (capture wins).
//   flags_sticky resets to 0.
//  FALU_STICKY_FLAGS_EN undefined: neither port exists; no extra logic.
// TESTING
//  Single op: push op_a=3F800000 op_b=40000000 op_code=0; model ALU returns 40400000, flags=0, 3 cycles after start
//   -> exactly one alu_start pulse; res_result=40400000, res_tag=0.
//  Fill: hold alu_ready=0 and push 5 commands with DEPTH=4 -> 4 accepted, cmd_ready=0, level=4, 5th held off until first pop.
//  Back-to-back: 3 queued ops -> 3 start pulses in FIFO order; res_tag=0,1,2; alu_* stable throughout every WAIT.
//  Tag wrap: 17 ops with TAG_W=4 -> the 17th result has res_tag=0.
//  Reset in WAIT: assert rst with 2 queued ops -> level=0, no res_valid, late alu_valid ignored, next result tag=0.
//  FALU_STICKY_FLAGS_EN: flags 00001 then 10000 -> flags_sticky=10001; flags_clr together with a capture of 00100 -> flags_sticky=00100.

Source files
------------

// File: rtl/float_alu_issue.sv
// ----------------------------------------------------------------------------
// float_alu_issue
//
// Issue stage sitting in front of float_alu. ALU commands are queued in a
// small FIFO. The FSM pops one command at a time into a set of held operand
// registers and pulses alu_start for a single cycle. It then waits for
// alu_valid and captures the result and flags, together with a sequence tag,
// for downstream writeback. Only one command is in flight at a time.
//
// Parameters
//   DEPTH  FIFO entries (power of 2, >= 2)
//   TAG_W  width of the result sequence tag
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (cmd_ready = FIFO not full)
//   cmd_op_code[2:0], cmd_round_mode, cmd_mode_fp, cmd_op_a[31:0],
//   cmd_op_b[31:0]           command fields
//   level                    FIFO occupancy, excluding the in-flight command
//   alu_start                one-cycle start pulse to float_alu
//   alu_op_code, alu_round_mode, alu_mode_fp, alu_op_a, alu_op_b
//                            operands held stable while the ALU works
//   alu_ready                float_alu ready_out
//   alu_valid                float_alu valid_out
//   alu_result[31:0], alu_flags[4:0]
//                            float_alu result and exception flags
//   res_valid                one-cycle strobe for the captured result
//   res_result, res_flags    captured result and flags
//   res_tag[TAG_W-1:0]       sequence number of the result (wraps)
//
// Optional build macro FALU_STICKY_FLAGS_EN adds:
//   flags_clr                clears the sticky flag accumulator
//   flags_sticky[4:0]        OR of the flags of every captured result
// A capture in the same cycle as flags_clr keeps that capture's flags.
// ----------------------------------------------------------------------------
module float_alu_issue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    // command side
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op_code,
    input  logic                     cmd_round_mode,
    input  logic                     cmd_mode_fp,
    input  logic [31:0]              cmd_op_a,
    input  logic [31:0]              cmd_op_b,
    output logic [$clog2(DEPTH):0]   level,
    // ALU side
    output logic                     alu_start,
    output logic [2:0]               alu_op_code,
    output logic                     alu_round_mode,
    output logic                     alu_mode_fp,
    output logic [31:0]              alu_op_a,
    output logic [31:0]              alu_op_b,
    input  logic                     alu_ready,
    input  logic                     alu_valid,
    input  logic [31:0]              alu_result,
    input  logic [4:0]               alu_flags,
`ifdef FALU_STICKY_FLAGS_EN
    input  logic                     flags_clr,
    output logic [4:0]               flags_sticky,
`endif
    // writeback side
    output logic                     res_valid,
    output logic [31:0]              res_result,
    output logic [4:0]               res_flags,
    output logic [TAG_W-1:0]         res_tag
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CMD_W = 3 + 1 + 1 + 32 + 32;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [CMD_W-1:0] w_head;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign cmd_ready = !w_full;
    assign level     = r_count;
    // No bypass: a full FIFO refuses the command even if a pop happens now.
    assign w_push    = cmd_valid && !w_full;
    assign w_head    = r_mem[r_rd_ptr];

    // Storage carries no reset; occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op_code, cmd_round_mode, cmd_mode_fp,
                                cmd_op_a, cmd_op_b};
        end
    end

    // DEPTH is a power of 2, so the AW-bit pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // alu_valid is only meaningful in WAIT; a stray strobe in IDLE/ISSUE
    // (e.g. from a command abandoned by reset) is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        alu_start   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && alu_ready) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_start   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (alu_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Held operands: loaded only on pop, so they stay constant through
    // ISSUE and WAIT.
    // ------------------------------------------------------------------
    logic [2:0]  r_alu_op_code;
    logic        r_alu_round_mode;
    logic        r_alu_mode_fp;
    logic [31:0] r_alu_op_a;
    logic [31:0] r_alu_op_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_op_code    <= '0;
            r_alu_round_mode <= 1'b0;
            r_alu_mode_fp    <= 1'b0;
            r_alu_op_a       <= '0;
            r_alu_op_b       <= '0;
        end else if (w_pop) begin
            {r_alu_op_code, r_alu_round_mode, r_alu_mode_fp,
             r_alu_op_a, r_alu_op_b} <= w_head;
        end
    end

    assign alu_op_code    = r_alu_op_code;
    assign alu_round_mode = r_alu_round_mode;
    assign alu_mode_fp    = r_alu_mode_fp;
    assign alu_op_a       = r_alu_op_a;
    assign alu_op_b       = r_alu_op_b;

    // ------------------------------------------------------------------
    // Result capture and sequence tag
    // ------------------------------------------------------------------
    logic             r_res_valid;
    logic [31:0]      r_res_result;
    logic [4:0]       r_res_flags;
    logic [TAG_W-1:0] r_res_tag;
    logic [TAG_W-1:0] r_issue_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid  <= 1'b0;
            r_res_result <= '0;
            r_res_flags  <= '0;
            r_res_tag    <= '0;
            r_issue_cnt  <= '0;
        end else begin
            r_res_valid <= w_capture;
            if (w_capture) begin
                r_res_result <= alu_result;
                r_res_flags  <= alu_flags;
                r_res_tag    <= r_issue_cnt;
                r_issue_cnt  <= r_issue_cnt + TAG_W'(1);
            end
        end
    end

    assign res_valid  = r_res_valid;
    assign res_result = r_res_result;
    assign res_flags  = r_res_flags;
    assign res_tag    = r_res_tag;

`ifdef FALU_STICKY_FLAGS_EN
    // ------------------------------------------------------------------
    // Sticky flag accumulator; a capture coinciding with a clear keeps
    // only the new flags.
    // ------------------------------------------------------------------
    logic [4:0] r_flags_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags_sticky <= '0;
        end else if (w_capture) begin
            r_flags_sticky <= (flags_clr ? 5'b0 : r_flags_sticky) | alu_flags;
        end else if (flags_clr) begin
            r_flags_sticky <= '0;
        end
    end

    assign flags_sticky = r_flags_sticky;
`endif

endmodule

// File: tb/tb_float_alu_issue.sv
// Directed testbench for float_alu_issue. The bench plays the role of
// float_alu itself: it watches alu_start, checks the held operands and
// returns a result a few cycles later.
module tb_float_alu_issue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op_code;
    logic        cmd_round_mode;
    logic        cmd_mode_fp;
    logic [31:0] cmd_op_a;
    logic [31:0] cmd_op_b;
    logic [$clog2(DEPTH):0] level;
    logic        alu_start;
    logic [2:0]  alu_op_code;
    logic        alu_round_mode;
    logic        alu_mode_fp;
    logic [31:0] alu_op_a;
    logic [31:0] alu_op_b;
    logic        alu_ready;
    logic        alu_valid;
    logic [31:0] alu_result;
    logic [4:0]  alu_flags;
    logic        flags_clr;
    logic [4:0]  flags_sticky;
    logic        res_valid;
    logic [31:0] res_result;
    logic [4:0]  res_flags;
    logic [TAG_W-1:0] res_tag;

    int checks   = 0;
    int failures = 0;
    logic [TAG_W-1:0] exp_tag;

    always #5 clk = ~clk;

    float_alu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op_code    (cmd_op_code),
        .cmd_round_mode (cmd_round_mode),
        .cmd_mode_fp    (cmd_mode_fp),
        .cmd_op_a       (cmd_op_a),
        .cmd_op_b       (cmd_op_b),
        .level          (level),
        .alu_start      (alu_start),
        .alu_op_code    (alu_op_code),
        .alu_round_mode (alu_round_mode),
        .alu_mode_fp    (alu_mode_fp),
        .alu_op_a       (alu_op_a),
        .alu_op_b       (alu_op_b),
        .alu_ready      (alu_ready),
        .alu_valid      (alu_valid),
        .alu_result     (alu_result),
        .alu_flags      (alu_flags),
`ifdef FALU_STICKY_FLAGS_EN
        .flags_clr      (flags_clr),
        .flags_sticky   (flags_sticky),
`endif
        .res_valid      (res_valid),
        .res_result     (res_result),
        .res_flags      (res_flags),
        .res_tag        (res_tag)
    );

`ifndef FALU_STICKY_FLAGS_EN
    assign flags_sticky = 5'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one command and hold it until the FIFO takes it.
    task automatic push(input logic [2:0] op, input logic rm, input logic fp,
                        input logic [31:0] a, input logic [31:0] b);
        int n;
        cmd_valid = 1'b1; cmd_op_code = op; cmd_round_mode = rm;
        cmd_mode_fp = fp; cmd_op_a = a; cmd_op_b = b;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("push_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // ALU busy phase: operands must stay put, then return the result.
    task automatic respond(input logic [31:0] ea, input logic [31:0] eb,
                           input logic [31:0] res, input logic [4:0] fl,
                           input logic clr);
        repeat (2) begin
            chk("hold_a", alu_op_a, ea);
            chk("hold_b", alu_op_b, eb);
            chk("no_restart", alu_start, 0);
            @(negedge clk);
        end
        alu_valid = 1'b1; alu_result = res; alu_flags = fl; flags_clr = clr;
        chk("hold_a_valid", alu_op_a, ea);
        @(negedge clk);
        alu_valid = 1'b0; alu_result = '0; alu_flags = '0; flags_clr = 1'b0;
        chk("res_valid", res_valid, 1);
        chk("res_result", res_result, res);
        chk("res_flags", {27'b0, res_flags}, {27'b0, fl});
        chk("res_tag", {28'b0, res_tag}, {28'b0, exp_tag});
        exp_tag = exp_tag + 1'b1;
        @(negedge clk);
        chk("res_valid_once", res_valid, 0);
    endtask

    task automatic serve(input logic [2:0] eop, input logic [31:0] ea,
                         input logic [31:0] eb, input logic [31:0] res,
                         input logic [4:0] fl, input logic clr);
        int n;
        n = 0;
        while (alu_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", alu_start, 1);
        chk("op_code", {29'b0, alu_op_code}, {29'b0, eop});
        chk("op_a", alu_op_a, ea);
        chk("op_b", alu_op_b, eb);
        @(negedge clk);
        chk("start_once", alu_start, 0);
        respond(ea, eb, res, fl, clr);
    endtask

    initial begin
        int n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op_code = '0; cmd_round_mode = 1'b0;
        cmd_mode_fp = 1'b0; cmd_op_a = '0; cmd_op_b = '0;
        alu_ready = 1'b1; alu_valid = 1'b0; alu_result = '0; alu_flags = '0;
        flags_clr = 1'b0; exp_tag = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_level", {28'b0, level}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_alu_op_a", alu_op_a, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_result", res_result, 0);
        chk("rst_res_tag", {28'b0, res_tag}, 0);
        chk("rst_sticky", {27'b0, flags_sticky}, 0);

        // Single op: 1.0 + 2.0 = 3.0
        push(3'd0, 1'b0, 1'b1, 32'h3F80_0000, 32'h4000_0000);
        chk("single_level", {28'b0, level}, 1);
        serve(3'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'b0, 1'b0);

        // Fill with the ALU stalled: four accepted, fifth held off
        alu_ready = 1'b0;
        for (int i = 1; i <= 4; i++)
            push(3'(i), 1'b0, 1'b1, 32'hA000_0000 + i, 32'hB000_0000 + i);
        chk("fill_level", {28'b0, level}, 4);
        chk("fill_ready", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_op_code = 3'd5; cmd_op_a = 32'hA000_0005;
        cmd_op_b = 32'hB000_0005;
        repeat (2) @(negedge clk);
        chk("fill_held_ready", cmd_ready, 0);
        chk("fill_held_level", {28'b0, level}, 4);
        alu_ready = 1'b1;
        @(negedge clk);
        chk("pop_level", {28'b0, level}, 3);
        chk("pop_ready", cmd_ready, 1);
        chk("pop_start", alu_start, 1);
        chk("pop_op_a", alu_op_a, 32'hA000_0001);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("fifth_level", {28'b0, level}, 4);
        chk("fifth_start_once", alu_start, 0);
        respond(32'hA000_0001, 32'hB000_0001, 32'h1111_0001, 5'b0, 1'b0);

        // Remaining queued ops drain back-to-back in FIFO order
        for (int i = 2; i <= 5; i++)
            serve(3'(i), 32'hA000_0000 + i, 32'hB000_0000 + i,
                  32'h1111_0000 + i, 5'(i), 1'b0);
        chk("drain_level", {28'b0, level}, 0);

        // Tag wrap: ops 7..17, the 17th result carries tag 0
        for (int i = 0; i < 11; i++) begin
            push(3'd1, 1'b1, 1'b0, 32'hC000_0000 + i, 32'hD000_0000 + i);
            serve(3'd1, 32'hC000_0000 + i, 32'hD000_0000 + i, 32'hE000_0000 + i,
                  5'b0, 1'b0);
        end
        chk("tag_wrap", {28'b0, res_tag}, 0);

        // Reset while the ALU is busy with queued work behind it
        alu_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push(3'd2, 1'b0, 1'b1, 32'h5000_0000 + i, 32'h6000_0000 + i);
        alu_ready = 1'b1;
        n = 0;
        while (alu_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rw_start", alu_start, 1);
        @(negedge clk);
        chk("rw_level_before", {28'b0, level}, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_level", {28'b0, level}, 0);
        chk("rw_cmd_ready", cmd_ready, 1);
        chk("rw_alu_op_a", alu_op_a, 0);
        chk("rw_res_tag", {28'b0, res_tag}, 0);
        alu_valid = 1'b1; alu_result = 32'hDEAD_BEEF; alu_flags = 5'b11111;
        @(negedge clk);
        alu_valid = 1'b0; alu_result = '0; alu_flags = '0;
        @(negedge clk);
        chk("rw_late_valid", res_valid, 0);
        chk("rw_late_result", res_result, 0);
        chk("rw_no_start", alu_start, 0);
        exp_tag = '0;
        push(3'd3, 1'b0, 1'b1, 32'h7000_0000, 32'h7100_0000);
        serve(3'd3, 32'h7000_0000, 32'h7100_0000, 32'h7200_0000, 5'b0, 1'b0);

`ifdef FALU_STICKY_FLAGS_EN
        // Sticky flags accumulate; clear coinciding with capture keeps new flags
        push(3'd4, 1'b0, 1'b1, 32'h1, 32'h2);
        serve(3'd4, 32'h1, 32'h2, 32'h3, 5'b00001, 1'b0);
        push(3'd4, 1'b0, 1'b1, 32'h4, 32'h5);
        serve(3'd4, 32'h4, 32'h5, 32'h6, 5'b10000, 1'b0);
        chk("sticky_or", {27'b0, flags_sticky}, 32'h11);
        push(3'd4, 1'b0, 1'b1, 32'h7, 32'h8);
        serve(3'd4, 32'h7, 32'h8, 32'h9, 5'b00100, 1'b1);
        chk("sticky_clr_capture", {27'b0, flags_sticky}, 32'h04);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        chk("sticky_clr", {27'b0, flags_sticky}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
